// File: rtl/borrow_lookahead_subtractor_pipe.sv
// Two-stage pipelined subtractor: diff = a - b - bin, using borrow lookahead
// inside 4-bit groups with group borrows rippling between groups. The low half
// is resolved in stage 1 and the high half in stage 2. Valid/ready on both
// sides gives full throughput with backpressure. WIDTH must be a multiple of 8.
module borrow_lookahead_subtractor_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int HALF = WIDTH / 2;
  localparam int NGRP = HALF / 4;

  // 4-bit borrow-lookahead group: every borrow is a flat sum of products of
  // generate/propagate terms and the group borrow-in. Returns {bout, d[3:0]}.
  function automatic logic [4:0] bla_group(input logic [3:0] a4,
                                           input logic [3:0] b4,
                                           input logic       bi);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] br;
    g     = ~a4 & b4;
    p     = ~(a4 ^ b4);
    br[0] = bi;
    br[1] = g[0] | (p[0] & bi);
    br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
    br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bi);
    br[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & bi);
    return {br[4], a4 ^ b4 ^ br[3:0]};
  endfunction

  // One half-width slice: group borrows ripple from group to group.
  // Returns {borrow_out, d[HALF-1:0]}.
  function automatic logic [HALF:0] sub_half(input logic [HALF-1:0] ah,
                                             input logic [HALF-1:0] bh,
                                             input logic            bi);
    logic [HALF-1:0] d;
    logic            br;
    logic [4:0]      grp;
    d  = '0;
    br = bi;
    for (int i = 0; i < NGRP; i++) begin
      grp          = bla_group(ah[i*4 +: 4], bh[i*4 +: 4], br);
      d[i*4 +: 4]  = grp[3:0];
      br           = grp[4];
    end
    return {br, d};
  endfunction

  logic            s1_valid_q, s1_valid_d;
  logic [HALF-1:0] s1_dlo_q,   s1_dlo_d;
  logic            s1_bmid_q,  s1_bmid_d;
  logic [HALF-1:0] s1_ahi_q,   s1_ahi_d;
  logic [HALF-1:0] s1_bhi_q,   s1_bhi_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] diff_q,      diff_d;
  logic             bout_q,      bout_d;
  logic             ovf_q,       ovf_d;
  logic             zero_q,      zero_d;
  logic             neg_q,       neg_d;

  logic             s2_advance;
  logic             accept;
  logic [HALF:0]    lo_res;
  logic [HALF:0]    hi_res;
  logic [WIDTH-1:0] full_diff;

  // Handshake: stage 2 moves when its slot is empty or being drained; stage 1
  // can take a bundle when empty or when it is moving into stage 2.
  always_comb begin
    s2_advance = s1_valid_q & (~out_valid_q | out_ready);
    in_ready   = ~s1_valid_q | s2_advance;
    accept     = in_valid & in_ready;
  end

  // Stage 1 next state: resolve the low half and capture the high operands.
  always_comb begin
    lo_res     = sub_half(a[HALF-1:0], b[HALF-1:0], bin);
    s1_dlo_d   = s1_dlo_q;
    s1_bmid_d  = s1_bmid_q;
    s1_ahi_d   = s1_ahi_q;
    s1_bhi_d   = s1_bhi_q;
    s1_valid_d = s1_valid_q;
    if (accept) begin
      s1_dlo_d   = lo_res[HALF-1:0];
      s1_bmid_d  = lo_res[HALF];
      s1_ahi_d   = a[WIDTH-1:HALF];
      s1_bhi_d   = b[WIDTH-1:HALF];
      s1_valid_d = 1'b1;
    end else if (s2_advance) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2 next state: resolve the high half and derive flags from the full diff.
  always_comb begin
    hi_res      = sub_half(s1_ahi_q, s1_bhi_q, s1_bmid_q);
    full_diff   = {hi_res[HALF-1:0], s1_dlo_q};
    diff_d      = diff_q;
    bout_d      = bout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    out_valid_d = out_valid_q;
    if (s2_advance) begin
      diff_d      = full_diff;
      bout_d      = hi_res[HALF];
      ovf_d       = (s1_ahi_q[HALF-1] != s1_bhi_q[HALF-1]) &&
                    (full_diff[WIDTH-1] != s1_ahi_q[HALF-1]);
      zero_d      = (full_diff == '0);
      neg_d       = full_diff[WIDTH-1];
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Pipeline registers; reset discards everything in flight immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_dlo_q    <= '0;
      s1_bmid_q   <= 1'b0;
      s1_ahi_q    <= '0;
      s1_bhi_q    <= '0;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_dlo_q    <= s1_dlo_d;
      s1_bmid_q   <= s1_bmid_d;
      s1_ahi_q    <= s1_ahi_d;
      s1_bhi_q    <= s1_bhi_d;
      out_valid_q <= out_valid_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
    end
  end

  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign neg       = neg_q;

endmodule

// File: doc/borrow_lookahead_subtractor_pipe.md
# borrow_lookahead_subtractor_pipe

Two-stage pipelined WIDTH-bit subtractor computing a − b − bin with borrow-lookahead logic in 4-bit groups. It is the subtract-direction counterpart to the team's 4-bit carry-lookahead adder and serves as the difference/compare unit for datapaths that need a registered, flow-controlled result. The low half of the operands is resolved in stage 1 and the high half in stage 2. Valid/ready handshakes on both sides give full throughput with backpressure.

## Interface
- WIDTH, 16, operand width; must be a multiple of 8 (each half a whole number of 4-bit groups)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high; clears all valid and output registers
- in_valid  input  1  operand bundle valid
- in_ready  output  1  block can accept the bundle this cycle
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- diff  output  WIDTH  (a − b − bin) mod 2^WIDTH
- bout  output  1  unsigned borrow-out: 1 iff a < b + bin
- ovf  output  1  signed overflow: a[MSB] != b[MSB] and diff[MSB] != a[MSB]
- zero  output  1  diff == 0
- neg  output  1  diff[MSB]

## Operation
- Per bit: generate borrow g_i = ~a_i & b_i; propagate p_i = ~(a_i ^ b_i); d_i = a_i ^ b_i ^ br_i; br_{i+1} = g_i | (p_i & br_i).
- Borrows are computed by lookahead within each 4-bit group (full sum-of-products, no ripple inside the group). Group borrows ripple between groups.
- Stage 1 (on accept: in_valid & in_ready):
  - computes the low WIDTH/2 bits of diff and the borrow into the high half from a, b, bin;
  - registers the low diff, the mid borrow, a[high], and b[high];
  - sets s1_valid.
- Stage 2 (on s1 advance):
  - computes the high half from the registered operands and the mid borrow;
  - registers the full diff, bout, ovf, zero, and neg;
  - sets out_valid.
- Flow control:
  - s2_advance = s1_valid & (~out_valid | out_ready)
  - in_ready = ~s1_valid | s2_advance
- A stage's registers load only when that stage advances. Otherwise they hold.
- out_valid clears when out_ready is high and no new result arrives.
- Results leave in acceptance order. None are dropped or duplicated.
- Flags are derived from the full registered diff and operand MSBs, never from partial halves.

## Timing
- Reset values: out_valid = 0, diff = 0, bout = 0, ovf = 0, zero = 0, neg = 0, s1_valid = 0. in_ready = 1 after reset.
- Reset mid-operation: both in-flight results are discarded immediately (asynchronously). No result appears after reset deassertion unless new input is accepted.
- Latency: a bundle accepted at edge N is presented with out_valid = 1 after edge N+1, assuming no stall.
- Throughput: one result per cycle while out_ready = 1.
- Stall: with out_valid = 1 and out_ready = 0:
  - diff and the flags hold stable;
  - stage 1 holds one further bundle;
  - in_ready drops only when both stages are full.
- Simultaneous events: on a full pipe with out_ready = 1 and in_valid = 1 in the same cycle, the output is consumed, stage 1 moves to stage 2, and the new bundle enters stage 1. There is no bubble.
- in_ready is combinational from out_ready. out_ready has no combinational path to diff or the flags.

## Test plan
- Reset, then 0x0000 − 0x0001 with bin = 0 → diff 0xFFFF, bout 1, ovf 0, neg 1, zero 0, out_valid exactly two edges after accept.
- 0x8000 − 0x0001 → diff 0x7FFF, bout 0, ovf 1, neg 0.
- 0x0100 − 0x0001 (borrow crosses stage boundary) → diff 0x00FF, bout 0. Also 0x1234 − 0x1234 with bin = 1 → 0xFFFF, bout 1. Also 0x5A5A − 0x5A5A with bin = 0 → 0x0000, zero 1.
- Back-to-back stream of 20 random bundles with out_ready = 1 → one result per cycle, all matching the reference model, in order.
- Backpressure:
  - hold out_ready = 0 while driving 3 bundles → in_ready falls after 2 are accepted, and diff stays stable;
  - release out_ready → the 3rd bundle is accepted and all 3 results arrive in order with none lost.
- Assert rst with 2 results in flight → out_valid = 0 and all outputs = 0 immediately. After release, the next bundle 0x0003 − 0x0001 yields 0x0002 with no stale results.
